// File: rtl/mem_copy_engine_if.sv
// Control and RAM-port signals of the memory copy/fill engine.
// master = engine side, slave = CPU register block plus RAM side.
interface mem_copy_engine_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              abort_i;
  logic              mode_i;
  logic [ADDR_W-1:0] src_addr_i;
  logic [ADDR_W-1:0] dst_addr_i;
  logic [ADDR_W:0]   length_i;
  logic [DATA_W-1:0] fill_data_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   word_count_o;
  logic [ADDR_W-1:0] mem_address_o;
  logic              mem_write_o;
  logic [DATA_W-1:0] mem_write_data_o;
  logic [DATA_W-1:0] mem_read_data_i;

  modport master (
    input  start_i, abort_i, mode_i, src_addr_i, dst_addr_i, length_i, fill_data_i,
           mem_read_data_i,
    output busy_o, done_o, word_count_o, mem_address_o, mem_write_o, mem_write_data_o
  );

  modport slave (
    output start_i, abort_i, mode_i, src_addr_i, dst_addr_i, length_i, fill_data_i,
           mem_read_data_i,
    input  busy_o, done_o, word_count_o, mem_address_o, mem_write_o, mem_write_data_o
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / constant fill bus master for the word-addressed data RAM.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for Start; RAM port quiet
//  RD    | read src+i; RAM data captured into data_q at the edge
//  WR    | write data_q to dst+i; advance word index
//  FILL  | write fill constant to dst+i; advance word index
//  DONE  | one-cycle Done pulse, then back to IDLE
module mem_copy_engine #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_copy_engine_if.master  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;

  // The word index doubles as WordCount: both equal the number of words written.
  logic [ADDR_W:0]   cnt_inc;
  logic              last_word;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);
  assign last_word = (cnt_inc == len_q);
  // Truncation to ADDR_W bits gives the required wrap 2**ADDR_W-1 -> 0.
  assign rd_addr   = src_q + cnt_q[ADDR_W-1:0];
  assign wr_addr   = dst_q + cnt_q[ADDR_W-1:0];

  // Next-state and job-register update.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        // Abort wins over a simultaneous Start: nothing is latched.
        if (bus.start_i && !bus.abort_i) begin
          src_d  = bus.src_addr_i;
          dst_d  = bus.dst_addr_i;
          len_d  = bus.length_i;
          fill_d = bus.fill_data_i;
          cnt_d  = '0;
          if (bus.length_i == '0) state_d = S_DONE;
          else if (bus.mode_i)    state_d = S_FILL;
          else                    state_d = S_RD;
        end
      end
      S_RD: begin
        data_d  = bus.mem_read_data_i;
        state_d = bus.abort_i ? S_DONE : S_WR;
      end
      S_WR: begin
        // The write is already on the bus this cycle, so it counts even on abort.
        cnt_d   = cnt_inc;
        state_d = (bus.abort_i || last_word) ? S_DONE : S_RD;
      end
      S_FILL: begin
        cnt_d   = cnt_inc;
        state_d = (bus.abort_i || last_word) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Outputs decoded from registered state only; quiet bus outside RD/WR/FILL.
  always_comb begin
    bus.busy_o           = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_FILL);
    bus.done_o           = (state_q == S_DONE);
    bus.word_count_o     = cnt_q;
    bus.mem_write_o      = (state_q == S_WR) || (state_q == S_FILL);
    bus.mem_address_o    = '0;
    bus.mem_write_data_o = '0;
    case (state_q)
      S_RD:    bus.mem_address_o = rd_addr;
      S_WR: begin
        bus.mem_address_o    = wr_addr;
        bus.mem_write_data_o = data_q;
      end
      S_FILL: begin
        bus.mem_address_o    = wr_addr;
        bus.mem_write_data_o = fill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: RAM model, job-level expected trace, literal spot checks.
module tb_mem_copy_engine;
  localparam int N = 16384;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [13:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [14:0] wc;
  } exp_t;

  // kind 0: RAM word, kind 1: WordCount output, kind 2: bounded wait expired
  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] addr;
    logic [31:0] val;
  } lit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  // RAM model: address latched on falling edge, write at rising edge.
  logic [31:0] ram [N];
  logic [13:0] ram_lat = '0;
  logic        pl_we = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(negedge clk) ram_lat <= bus.mem_address_o;
  assign bus.mem_read_data_i = ram[ram_lat];
  always @(posedge clk) begin
    if (bus.mem_write_o) ram[bus.mem_address_o] <= bus.mem_write_data_o;
    else if (pl_we)      ram[pl_addr] <= pl_data;
  end

  logic [31:0] refmem [N];
  exp_t expq[$];
  lit_t litq[$];
  int   checks = 0;
  int   errors = 0;
  logic [14:0] idle_wc = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Single checking process: per-cycle trace plus queued literal checks.
  always @(negedge clk) begin
    exp_t e;
    lit_t l;
    if (rst) idle_wc = '0;
    if (expq.size() != 0) e = expq.pop_front();
    else begin
      e = '0;
      e.wc = idle_wc;
    end
    if (e.done) idle_wc = e.wc;
    cmp("busy",  32'(bus.busy_o),           32'(e.busy));
    cmp("done",  32'(bus.done_o),           32'(e.done));
    cmp("addr",  32'(bus.mem_address_o),    32'(e.addr));
    cmp("we",    32'(bus.mem_write_o),      32'(e.we));
    cmp("wdata", bus.mem_write_data_o,      e.wdata);
    cmp("wcnt",  32'(bus.word_count_o),     32'(e.wc));
    while (litq.size() != 0) begin
      l = litq.pop_front();
      case (l.kind)
        2'd0:    cmp($sformatf("ram[%h]", l.addr), ram[l.addr], l.val);
        2'd1:    cmp("wordcount_lit", 32'(bus.word_count_o), l.val);
        default: cmp("wait_bound", 32'd1, 32'd0);
      endcase
    end
  end

  function automatic exp_t mk(logic b, logic d, int a, logic w, logic [31:0] wd, int wc);
    exp_t e;
    e.busy = b; e.done = d; e.addr = 14'(a % N); e.we = w; e.wdata = wd; e.wc = 15'(wc);
    return e;
  endfunction

  task automatic lit_ram(input int a, input logic [31:0] v);
    litq.push_back({2'd0, 14'(a), v});
  endtask

  task automatic lit_wc(input int v);
    litq.push_back({2'd1, 14'd0, 32'(v)});
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    @(negedge clk); #1;
    pl_we = 1'b1; pl_addr = 14'(a); pl_data = v;
    refmem[a % N] = v;
    @(negedge clk); #1;
    pl_we = 1'b0;
  endtask

  // cut_kind: 0 none, 1 abort during active cycle cut_at, 2 reset during cycle cut_at.
  task automatic job(input bit mode, input int src, input int dst, input int len,
                     input logic [31:0] fill, input int cut_kind, input int cut_at,
                     input int restart_at);
    int n, written;
    bit stop, done_loop;
    logic [31:0] v;
    @(negedge clk); #1;
    bus.mode_i = mode; bus.src_addr_i = 14'(src); bus.dst_addr_i = 14'(dst);
    bus.length_i = 15'(len); bus.fill_data_i = fill; bus.start_i = 1'b1;
    n = 0; written = 0; stop = 1'b0;
    for (int k = 0; k < len && !stop; k++) begin
      if (!mode) begin
        expq.push_back(mk(1, 0, src + k, 0, 32'd0, written));
        if (cut_kind != 0 && n == cut_at) stop = 1'b1;
        n++;
        if (!stop) begin
          v = refmem[(src + k) % N];
          expq.push_back(mk(1, 0, dst + k, 1, v, written));
          refmem[(dst + k) % N] = v;
          written++;
          if (cut_kind != 0 && n == cut_at) stop = 1'b1;
          n++;
        end
      end else begin
        expq.push_back(mk(1, 0, dst + k, 1, fill, written));
        refmem[(dst + k) % N] = fill;
        written++;
        if (cut_kind != 0 && n == cut_at) stop = 1'b1;
        n++;
      end
    end
    if (cut_kind != 2) expq.push_back(mk(0, 1, 0, 0, 32'd0, written));
    done_loop = 1'b0;
    for (int cyc = 0; cyc < 40000 && !done_loop; cyc++) begin
      @(negedge clk); #1;
      bus.start_i = (cyc == restart_at);
      bus.abort_i = (cut_kind == 1 && cyc == cut_at);
      rst         = (cut_kind == 2 && cyc == cut_at);
      if (cyc == 0) begin
        // Job registers are latched; scramble the inputs to prove it.
        bus.src_addr_i = 14'h2AAA; bus.dst_addr_i = 14'h1555;
        bus.length_i = 15'd2; bus.fill_data_i = 32'h0BAD_0BAD; bus.mode_i = ~mode;
      end
      if (expq.size() == 0 && cyc > cut_at && cyc > restart_at && !rst) done_loop = 1'b1;
    end
    if (!done_loop) litq.push_back({2'd2, 14'd0, 32'd0});
    bus.start_i = 1'b0; bus.abort_i = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.mode_i = 1'b0;
    bus.src_addr_i = '0; bus.dst_addr_i = '0; bus.length_i = '0; bus.fill_data_i = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Plain copy of four words
    for (int k = 0; k < 4; k++) preload(32'h100 + k, 32'(k + 1));
    job(1'b0, 'h100, 'h200, 4, 32'd0, 0, -1, -1);
    for (int k = 0; k < 4; k++) lit_ram('h200 + k, 32'(k + 1));
    lit_wc(4);

    // Fill wrapping through the top of memory
    job(1'b1, 0, 'h3FFE, 4, 32'hDEADBEEF, 0, -1, -1);
    lit_ram('h3FFE, 32'hDEADBEEF); lit_ram('h3FFF, 32'hDEADBEEF);
    lit_ram('h0000, 32'hDEADBEEF); lit_ram('h0001, 32'hDEADBEEF);
    lit_wc(4);

    // Zero length
    job(1'b0, 'h100, 'h300, 0, 32'd0, 0, -1, -1);
    lit_wc(0);

    // Overlapping forward copy replicates the leading word
    for (int k = 0; k < 4; k++) preload('h10 + k, 32'hA + 32'(k));
    job(1'b0, 'h10, 'h11, 3, 32'd0, 0, -1, -1);
    lit_ram('h10, 32'hA); lit_ram('h11, 32'hA); lit_ram('h12, 32'hA); lit_ram('h13, 32'hA);

    // Abort on the third WR cycle (active cycle 5), Start pulsed mid-job
    for (int k = 0; k < 8; k++) preload('h400 + k, 32'h400 + 32'(k));
    preload('h503, 32'h55);
    job(1'b0, 'h400, 'h500, 8, 32'd0, 1, 5, 2);
    lit_ram('h500, 32'h400); lit_ram('h501, 32'h401); lit_ram('h502, 32'h402);
    lit_ram('h503, 32'h55);
    lit_wc(3);

    // Start together with Abort in IDLE: no job
    @(negedge clk); #1;
    bus.start_i = 1'b1; bus.abort_i = 1'b1; bus.length_i = 15'd4; bus.mode_i = 1'b1;
    @(negedge clk); #1;
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    @(negedge clk); #1;
    lit_wc(3);

    // Reset mid-fill after two words
    for (int k = 0; k < 4; k++) preload('h600 + k, 32'h0);
    job(1'b1, 0, 'h600, 4, 32'h12345678, 2, 1, -1);
    lit_ram('h600, 32'h12345678); lit_ram('h601, 32'h12345678);
    lit_ram('h602, 32'h0); lit_ram('h603, 32'h0);
    lit_wc(0);

    // Copy across the wrap after the reset
    preload('h3FFF, 32'h600D);
    job(1'b0, 'h3FFF, 'h700, 3, 32'd0, 0, -1, -1);
    lit_ram('h700, 32'h600D); lit_ram('h701, 32'hDEADBEEF); lit_ram('h702, 32'hDEADBEEF);
    lit_wc(3);

    // Full-memory fill, Length = 16384
    job(1'b1, 0, 5, 16384, 32'h77, 0, -1, -1);
    lit_ram(4, 32'h77); lit_ram(5, 32'h77); lit_ram('h2000, 32'h77);
    lit_wc(16384);

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
